// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types for the HI/LO write pipeline.
package hilo_pkg;
    typedef struct packed {
        logic        we_hi;
        logic        we_lo;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_wr_t;

    localparam hilo_wr_t HILO_WR_NONE = '0;
endpackage

// File: rtl/hilo_if.sv
// hilo_if: execute-stage HI/LO write request, pipeline control and HI/LO read-back.
interface hilo_if;
    logic        we_hi_e;
    logic        we_lo_e;
    logic [31:0] hi_e;
    logic [31:0] lo_e;
    logic        stall;
    logic        flush;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] hi_arch;
    logic [31:0] lo_arch;

    modport master (
        output we_hi_e, we_lo_e, hi_e, lo_e, stall, flush,
        input  hi_o, lo_o, hi_arch, lo_arch
    );

    modport slave (
        input  we_hi_e, we_lo_e, hi_e, lo_e, stall, flush,
        output hi_o, lo_o, hi_arch, lo_arch
    );
endinterface

// File: rtl/hilo_slot.sv
// hilo_slot: one pending HI/LO write pipeline register; stall holds, kill clears.
module hilo_slot
    import hilo_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    input  hilo_wr_t d,
    input  logic     stall,
    input  logic     kill,
    output hilo_wr_t q
);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn)
            q <= HILO_WR_NONE;
        else if (!stall)
            q <= kill ? HILO_WR_NONE : d;
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: M/W pending HI/LO writes, committed HI/LO registers and
// per-half forwarding to the instruction in execute.
module hilo_unit
    import hilo_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    hilo_if.slave bus
);
    hilo_wr_t    e_wr, m_wr, w_wr;
    logic [31:0] hi_r, lo_r;

    assign e_wr = '{we_hi: bus.we_hi_e, we_lo: bus.we_lo_e, hi: bus.hi_e, lo: bus.lo_e};

    hilo_slot u_m (.clk(clk), .resetn(resetn), .d(e_wr), .stall(bus.stall), .kill(bus.flush), .q(m_wr));
    hilo_slot u_w (.clk(clk), .resetn(resetn), .d(m_wr), .stall(bus.stall), .kill(bus.flush), .q(w_wr));

    // W is older than a faulting M instruction, so it commits even on flush
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (!bus.stall) begin
            if (w_wr.we_hi) hi_r <= w_wr.hi;
            if (w_wr.we_lo) lo_r <= w_wr.lo;
        end

    assign bus.hi_o    = m_wr.we_hi ? m_wr.hi : w_wr.we_hi ? w_wr.hi : hi_r;
    assign bus.lo_o    = m_wr.we_lo ? m_wr.lo : w_wr.we_lo ? w_wr.lo : lo_r;
    assign bus.hi_arch = hi_r;
    assign bus.lo_arch = lo_r;
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed and random stimulus checked against an in-flight-write queue model.
module tb_hilo_unit;
    import hilo_pkg::*;

    logic clk = 0;
    logic resetn = 0;
    int   vectors = 0;
    int   errors = 0;

    hilo_if bus();
    hilo_unit dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    // model: pend[0] is the youngest in-flight write, pend[1] the oldest
    hilo_wr_t    pend [2];
    logic [31:0] arch_hi, arch_lo;

    function automatic logic [31:0] model_read(input bit is_hi);
        for (int i = 0; i < 2; i++)
            if (is_hi ? pend[i].we_hi : pend[i].we_lo)
                return is_hi ? pend[i].hi : pend[i].lo;
        return is_hi ? arch_hi : arch_lo;
    endfunction

    task automatic model_reset();
        pend[0] = HILO_WR_NONE;
        pend[1] = HILO_WR_NONE;
        arch_hi = 0;
        arch_lo = 0;
    endtask

    task automatic model_edge(input hilo_wr_t e, input logic st, input logic fl);
        if (st) return;
        if (pend[1].we_hi) arch_hi = pend[1].hi;
        if (pend[1].we_lo) arch_lo = pend[1].lo;
        pend[1] = fl ? HILO_WR_NONE : pend[0];
        pend[0] = fl ? HILO_WR_NONE : e;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("hi_o", bus.hi_o, model_read(1));
        chk("lo_o", bus.lo_o, model_read(0));
        chk("hi_arch", bus.hi_arch, arch_hi);
        chk("lo_arch", bus.lo_arch, arch_lo);
    endtask

    // drive one cycle of inputs, advance the model at the edge, compare at the falling edge
    task automatic step(input logic wh, input logic wl, input logic [31:0] h, input logic [31:0] l,
                        input logic st, input logic fl);
        hilo_wr_t e;
        e = '{we_hi: wh, we_lo: wl, hi: h, lo: l};
        bus.we_hi_e = wh;
        bus.we_lo_e = wl;
        bus.hi_e    = h;
        bus.lo_e    = l;
        bus.stall   = st;
        bus.flush   = fl;
        @(posedge clk);
        model_edge(e, st, fl);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        bus.we_hi_e = 0;
        bus.we_lo_e = 0;
        bus.hi_e = 0;
        bus.lo_e = 0;
        bus.stall = 0;
        bus.flush = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
        check_model();
        chk("reset hi_arch", bus.hi_arch, 32'h0);

        // MULT: forwarded in t+1 and t+2, committed visible in t+3
        step(1, 1, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0);
        chk("mult hi_o t+1", bus.hi_o, 32'h1);
        chk("mult lo_o t+1", bus.lo_o, 32'hFFFF_FFFE);
        chk("mult hi_arch t+1", bus.hi_arch, 32'h0);
        idle(1);
        chk("mult lo_o t+2", bus.lo_o, 32'hFFFF_FFFE);
        chk("mult lo_arch t+2", bus.lo_arch, 32'h0);
        idle(1);
        chk("mult hi_arch t+3", bus.hi_arch, 32'h1);
        chk("mult lo_arch t+3", bus.lo_arch, 32'hFFFF_FFFE);

        // MULTU then MTHI: per-half forwarding from different stages
        step(1, 1, 32'hAAAA_AAAA, 32'h5555_5555, 0, 0);
        step(1, 0, 32'h1234_5678, 32'h0, 0, 0);
        chk("split hi_o", bus.hi_o, 32'h1234_5678);
        chk("split lo_o", bus.lo_o, 32'h5555_5555);
        idle(2);
        chk("split hi_arch", bus.hi_arch, 32'h1234_5678);
        chk("split lo_arch", bus.lo_arch, 32'h5555_5555);

        // stall while LO write sits in W
        step(0, 1, 32'h0, 32'hDEAD_BEEF, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0);
            chk("stall lo_arch held", bus.lo_arch, 32'h5555_5555);
            chk("stall lo_o", bus.lo_o, 32'hDEAD_BEEF);
        end
        idle(1);
        chk("stall commit", bus.lo_arch, 32'hDEAD_BEEF);

        // flush kills M (7) but W (3) still commits
        step(0, 1, 32'h0, 32'h0000_0003, 0, 0);
        step(0, 1, 32'h0, 32'h0000_0007, 0, 0);
        chk("pre-flush lo_o", bus.lo_o, 32'h7);
        step(0, 0, 0, 0, 0, 1);
        chk("flush lo_arch", bus.lo_arch, 32'h3);
        chk("flush lo_o", bus.lo_o, 32'h3);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("post-flush lo_arch", bus.lo_arch, 32'h3);
            chk("post-flush lo_o", bus.lo_o, 32'h3);
        end

        // stall dominates flush: nothing killed
        step(1, 0, 32'h0000_00AB, 32'h0, 0, 0);
        step(1, 0, 32'h0000_00CD, 32'h0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("stall+flush hi_o", bus.hi_o, 32'hCD);
        idle(1);
        chk("stall+flush hi_arch ab", bus.hi_arch, 32'hAB);
        idle(1);
        chk("stall+flush hi_arch cd", bus.hi_arch, 32'hCD);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), $urandom, $urandom,
                 $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);

        // asynchronous reset with both slots full, stall and flush asserted
        step(1, 1, 32'h1111_1111, 32'h2222_2222, 0, 0);
        step(1, 1, 32'h3333_3333, 32'h4444_4444, 0, 0);
        bus.stall = 1;
        bus.flush = 1;
        #2 resetn = 0;
        #1;
        model_reset();
        chk("async reset hi_o", bus.hi_o, 32'h0);
        chk("async reset lo_o", bus.lo_o, 32'h0);
        chk("async reset hi_arch", bus.hi_arch, 32'h0);
        chk("async reset lo_arch", bus.lo_arch, 32'h0);
        @(negedge clk);
        resetn = 1;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/hilo_unit.md
# hilo_unit

Consumer side of the execute-stage multiply/divide result: holds pending HI/LO writes as they travel through the M and W pipeline stages, commits them to the architectural HI/LO registers, and serves mfhi/mflo reads with forwarding from in-flight writes. Sits beside the execute stage. Takes the per-half write request produced for MULT/MULTU/DIV/DIVU/MTHI/MTLO and returns the current HI/LO value seen by the instruction now in execute.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  core clock; all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- we_hi_e  in  1  instruction in E writes HI.
- we_lo_e  in  1  instruction in E writes LO.
- hi_e  in  32  HI value from E (mult/div result or rs for MTHI).
- lo_e  in  32  LO value from E.
- stall  in  1  freeze: no stage advances, no commit.
- flush  in  1  exception at M: kill E input and M entry.
- hi_o  out  32  forwarded HI for the instruction in E.
- lo_o  out  32  forwarded LO for the instruction in E.
- hi_arch  out  32  committed HI register.
- lo_arch  out  32  committed LO register.

## Operation
- Three state groups:
  - M slot: {we_hi, we_lo, hi, lo}.
  - W slot: same fields.
  - Committed hi_r/lo_r.
- Slot valid for a half means its write-enable for that half is set; no separate valid bit.
- Per edge, stall=0, flush=0:
  - M ← E inputs.
  - W ← M.
  - Each half of hi_r/lo_r whose W enable is set ← W data.
- stall=1: all three groups hold; E inputs ignored. stall dominates flush.
- flush=1, stall=0:
  - M ← all-zero, both enables cleared.
  - W ← all-zero; the killed M entry never reaches W.
  - The current W entry still commits on this edge, because it is older than the faulting instruction.
- Forwarding, per half independently, combinational:
  - M enable set: use M data.
  - Otherwise W enable set: use W data.
  - Otherwise: committed register.
  - MTHI in M followed by MULT in W yields hi_o = M.hi and lo_o = W.lo.
- E inputs are never forwarded to hi_o/lo_o. An instruction does not read its own write.
- Data passes through unmodified; no arithmetic in this block.

## Timing
- Reset (resetn=0, asynchronous): hi_r=lo_r=0, both slots cleared.
  - hi_o=lo_o=hi_arch=lo_arch=0 immediately.
  - Reset takes effect mid-operation regardless of stall or flush; any in-flight write is lost.
- Write presented in E at edge t, with no stall and no flush through t+2:
  - In M after t; visible on hi_o/lo_o during cycle t+1.
  - In W after t+1.
  - Committed after t+2; hi_arch changes in cycle t+3.
- Each stalled cycle extends every latency by exactly one.
- hi_o/lo_o are purely combinational from slot and register state.
- hi_arch/lo_arch are direct register outputs, with no combinational path from inputs.
- Back-to-back writes to the same half: the youngest (M) wins on forwarding, and commits occur in order.

## Structure
- Package hilo_pkg:
  - typedef struct packed hilo_wr_t {we_hi, we_lo, hi[31:0], lo[31:0]}.
  - Constant HILO_WR_NONE = '0.
- Sub-module hilo_slot: one hilo_wr_t pipeline register with inputs d, stall, kill, asynchronous reset; q output. Instantiate twice, for M and W.
- Top level holds the committed registers and the forwarding muxes.

## Test plan
- Reset: drive resetn=0 mid-stream with M/W full -> hi_o, lo_o, hi_arch and lo_arch read 0 before the next edge.
- MULT commit: we_hi_e=we_lo_e=1, hi_e=32'h0000_0001, lo_e=32'hFFFF_FFFE for one cycle ->
  - hi_o=1 and lo_o=FFFF_FFFE in cycles t+1 and t+2.
  - hi_arch/lo_arch update in cycle t+3.
- Split forwarding: MULTU (hi=AAAA_AAAA, lo=5555_5555), then MTHI (hi=1234_5678) on the next cycle -> the following cycle reads hi_o=1234_5678, lo_o=5555_5555. Final commit: hi=1234_5678, lo=5555_5555.
- Stall: write DEAD_BEEF to LO, then stall=1 for 3 cycles starting when it is in W -> lo_arch unchanged during the stall; commits on the first unstalled edge.
- Flush: write lo=0000_0007 (in M) with a different write lo=0000_0003 in W, then assert flush for one cycle -> lo_arch=3, and 7 never appears on lo_arch or lo_o afterward.
- Stall+flush together: stall=1, flush=1 -> all state held, nothing killed.
